// File: rtl/register_file.sv
// rtl/register_file.sv - two-read/one-write register bank with a handshaked dump engine
// Optional feature: define REG_FILE_BYPASS_EN for same-cycle write-through on both read ports.
module register_file #(
   parameter int NB_DATA      = 16,
   parameter int NB_REGISTERS = 5
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_reg_write,
   input  logic [NB_REGISTERS-1:0] i_reg_num,
   input  logic [NB_DATA-1:0]      i_reg_w_data,
   input  logic [NB_REGISTERS-1:0] i_rs_num,
   input  logic [NB_REGISTERS-1:0] i_rt_num,
   output logic [NB_DATA-1:0]      o_rs_data,
   output logic [NB_DATA-1:0]      o_rt_data,
   input  logic                    i_dump_start,
   input  logic                    i_dump_ready,
   output logic                    o_dump_valid,
   output logic [NB_REGISTERS-1:0] o_dump_addr,
   output logic [NB_DATA-1:0]      o_dump_data,
   output logic                    o_dump_done,
   output logic                    o_dump_busy
);

   localparam int N_REGS = 2 ** NB_REGISTERS;
   localparam logic [NB_REGISTERS-1:0] LAST_IDX = NB_REGISTERS'(N_REGS - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SEND = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [NB_DATA-1:0]      regs_q [N_REGS];
   logic [1:0]              state_q, state_d;
   logic [NB_REGISTERS-1:0] idx_q, idx_d;
   logic [NB_REGISTERS-1:0] idx_next;
   logic [NB_DATA-1:0]      data_q, data_d;

   // Register 0 is never written, so it stays at its reset value of zero.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         for (int i = 0; i < N_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (i_reg_write && (i_reg_num != '0)) begin
         regs_q[i_reg_num] <= i_reg_w_data;
      end
   end

   always_comb begin
      o_rs_data = regs_q[i_rs_num];
      o_rt_data = regs_q[i_rt_num];
`ifdef REG_FILE_BYPASS_EN
      if (i_reg_write && (i_reg_num != '0) && (i_reg_num == i_rs_num)) begin
         o_rs_data = i_reg_w_data;
      end
      if (i_reg_write && (i_reg_num != '0) && (i_reg_num == i_rt_num)) begin
         o_rt_data = i_reg_w_data;
      end
`endif
   end

   assign idx_next = idx_q + 1'b1;

   // Snapshot reads the array before this edge's write lands, so a same-cycle
   // write to the next index is not seen by the beat being loaded.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      data_d  = data_q;
      case (state_q)
         ST_IDLE: begin
            if (i_dump_start) begin
               state_d = ST_SEND;
               idx_d   = '0;
               data_d  = regs_q[0];
            end
         end
         ST_SEND: begin
            if (i_dump_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = ST_DONE;
                  idx_d   = '0;
               end else begin
                  idx_d  = idx_next;
                  data_d = regs_q[idx_next];
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
      end
   end

   assign o_dump_valid = (state_q == ST_SEND);
   assign o_dump_addr  = idx_q;
   assign o_dump_data  = data_q;
   assign o_dump_done  = (state_q == ST_DONE);
   assign o_dump_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - randomized self-checking bench for register_file against a behavioural model
module tb_register_file;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b0;
   logic        i_reg_write = 1'b0;
   logic [4:0]  i_reg_num = '0;
   logic [15:0] i_reg_w_data = '0;
   logic [4:0]  i_rs_num = '0;
   logic [4:0]  i_rt_num = '0;
   logic [15:0] o_rs_data, o_rt_data;
   logic        i_dump_start = 1'b0;
   logic        i_dump_ready = 1'b0;
   logic        o_dump_valid;
   logic [4:0]  o_dump_addr;
   logic [15:0] o_dump_data;
   logic        o_dump_done, o_dump_busy;

   register_file #(.NB_DATA(16), .NB_REGISTERS(5)) dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_reg_write(i_reg_write), .i_reg_num(i_reg_num), .i_reg_w_data(i_reg_w_data),
      .i_rs_num(i_rs_num), .i_rt_num(i_rt_num),
      .o_rs_data(o_rs_data), .o_rt_data(o_rt_data),
      .i_dump_start(i_dump_start), .i_dump_ready(i_dump_ready),
      .o_dump_valid(o_dump_valid), .o_dump_addr(o_dump_addr), .o_dump_data(o_dump_data),
      .o_dump_done(o_dump_done), .o_dump_busy(o_dump_busy)
   );

   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: register contents plus a dump described as
   // "not dumping / sending beat k with a snapshot value / finished".
   logic [15:0] m_regs [32];
   bit          m_sending;
   bit          m_finished;
   int          m_beat;
   logic [15:0] m_snap;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [15:0] exp_read(input logic [4:0] a);
      if (a == 0) return 16'h0;
`ifdef REG_FILE_BYPASS_EN
      if (i_reg_write && i_reg_num == a) return i_reg_w_data;
`endif
      return m_regs[a];
   endfunction

   task automatic model_reset();
      foreach (m_regs[i]) m_regs[i] = 16'h0;
      m_sending  = 0;
      m_finished = 0;
      m_beat     = 0;
      m_snap     = 16'h0;
   endtask

   // Drive inputs (called at a negedge), then check every output against the model.
   task automatic drive_check(input bit wr, input logic [4:0] num, input logic [15:0] wd,
                              input logic [4:0] rs, input logic [4:0] rt,
                              input bit start, input bit ready);
      i_reg_write = wr; i_reg_num = num; i_reg_w_data = wd;
      i_rs_num = rs; i_rt_num = rt; i_dump_start = start; i_dump_ready = ready;
      #1;
      check("rs_data", o_rs_data, exp_read(rs));
      check("rt_data", o_rt_data, exp_read(rt));
      check("dump_valid", o_dump_valid, m_sending);
      check("dump_done", o_dump_done, m_finished);
      check("dump_busy", o_dump_busy, m_sending || m_finished);
      if (m_sending) begin
         check("dump_addr", o_dump_addr, m_beat);
         check("dump_data", o_dump_data, m_snap);
      end
   endtask

   // Advance the model across one rising edge, then settle at the next negedge.
   task automatic tick();
      logic [15:0] pre [32];
      @(posedge i_clk);
      pre = m_regs;
      if (m_finished) begin
         m_finished = 0;
      end else if (m_sending) begin
         if (i_dump_ready) begin
            if (m_beat == 31) begin
               m_sending = 0; m_finished = 1;
            end else begin
               m_beat++;
               m_snap = pre[m_beat];
            end
         end
      end else if (i_dump_start) begin
         m_sending = 1; m_beat = 0; m_snap = pre[0];
      end
      if (i_reg_write && i_reg_num != 0) m_regs[i_reg_num] = i_reg_w_data;
      @(negedge i_clk);
   endtask

   task automatic do_reset();
      i_reset = 1'b0;
      model_reset();
      i_rs_num = 5'($urandom_range(1, 31)); i_rt_num = 5'($urandom_range(1, 31));
      i_reg_write = 0; i_dump_start = 0;
      #1;
      check("rst_rs", o_rs_data, 16'h0);
      check("rst_rt", o_rt_data, 16'h0);
      check("rst_valid", o_dump_valid, 1'b0);
      check("rst_addr", o_dump_addr, 5'h0);
      check("rst_data", o_dump_data, 16'h0);
      check("rst_done", o_dump_done, 1'b0);
      check("rst_busy", o_dump_busy, 1'b0);
      @(posedge i_clk);
      @(negedge i_clk);
      i_reset = 1'b1;
   endtask

   initial begin
      int beats, dones;
      bit written;
      model_reset();
      @(negedge i_clk);
      do_reset();

      // Write reg 4 and read it on both ports.
      drive_check(1, 5'd4, 16'h0001, 5'd1, 5'd2, 0, 0); tick();
      drive_check(0, 5'd0, 16'h0, 5'd4, 5'd4, 0, 0);
      check("reg4_rs", o_rs_data, 16'h0001);
      check("reg4_rt", o_rt_data, 16'h0001);
      tick();

      // Writes to register 0 are dropped.
      drive_check(1, 5'd0, 16'hFFFF, 5'd0, 5'd0, 0, 0); tick();
      drive_check(0, 5'd0, 16'h0, 5'd0, 5'd4, 0, 0);
      check("reg0_rs", o_rs_data, 16'h0000);
      tick();

      // Same-cycle write and read of reg 7.
      drive_check(1, 5'd7, 16'h00AA, 5'd7, 5'd4, 0, 0);
`ifdef REG_FILE_BYPASS_EN
      check("reg7_same", o_rs_data, 16'h00AA);
`else
      check("reg7_same", o_rs_data, 16'h0000);
`endif
      tick();
      drive_check(0, 5'd0, 16'h0, 5'd7, 5'd0, 0, 0);
      check("reg7_after", o_rs_data, 16'h00AA);
      tick();

      // Mid-run reset wipes the bank.
      do_reset();
      drive_check(0, 5'd0, 16'h0, 5'd7, 5'd4, 0, 0);
      check("post_rst_reg7", o_rs_data, 16'h0);
      tick();

      // Full dump with ready held high.
      for (int i = 1; i < 32; i++) begin
         drive_check(1, 5'(i), 16'(i + 1), 5'($urandom), 5'($urandom), 0, 0); tick();
      end
      drive_check(0, 5'd0, 16'h0, 5'd0, 5'd0, 1, 1); tick();
      beats = 0; dones = 0;
      for (int k = 0; k < 40; k++) begin
         drive_check(0, 5'd0, 16'h0, 5'($urandom), 5'($urandom), 0, 1);
         if (o_dump_valid) begin
            check("d5_addr", o_dump_addr, beats);
            check("d5_data", o_dump_data, (beats == 0) ? 16'h0 : 16'(beats + 1));
            beats++;
         end
         if (o_dump_done) dones++;
         tick();
      end
      check("d5_beats", beats, 32);
      check("d5_dones", dones, 1);
      check("d5_busy", o_dump_busy, 1'b0);

      // Dump with toggling ready, held-beat write, ignored start, reset at beat 10.
      drive_check(0, 5'd0, 16'h0, 5'd0, 5'd0, 1, 0); tick();
      written = 0; dones = 0;
      for (int k = 0; k < 60; k++) begin
         if (m_sending && m_beat == 10) break;
         if (m_sending && m_beat == 3 && written) begin
            drive_check(0, 5'd0, 16'h0, 5'd3, 5'd0, 0, k[0]);
            check("d6_hold", o_dump_data, 16'h0004);
         end else if (m_sending && m_beat == 3 && !k[0]) begin
            drive_check(1, 5'd3, 16'h1234, 5'd3, 5'd0, 0, 0);
            written = 1;
         end else begin
            drive_check(0, 5'd0, 16'h0, 5'($urandom), 5'($urandom), k == 5, k[0]);
         end
         if (o_dump_done) dones++;
         tick();
      end
      check("d6_reached10", m_beat, 10);
      do_reset();
      for (int k = 0; k < 40; k++) begin
         drive_check(0, 5'd0, 16'h0, 5'd3, 5'd0, 0, 1);
         if (o_dump_done) dones++;
         tick();
      end
      check("d6_no_done", dones, 0);

      // Random traffic.
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 499) == 0) do_reset();
         drive_check($urandom_range(0, 1), 5'($urandom), 16'($urandom), 5'($urandom),
                     5'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
